// File: rtl/uart_rx_fifo.sv
// Oversampled RS-232 receiver with parity/framing/break flags and a first-word-fall-through FIFO.
// Define UART_RX_PARITY_EN to expect one parity bit after the data bits.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 2000000,
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 8,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          m_perr,
  output logic                          m_ferr,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          break_det
);

  // state     | meaning
  // IDLE      | line idle, waiting for filtered bit to fall
  // START     | validating start bit at its mid-point
  // DATA      | shifting in DATA_BITS, LSB first
  // PARITY    | sampling the parity bit
  // STOP      | sampling stop bit, pushing the character
  // WAIT_IDLE | after a framing error, waiting for the line to return high
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

  localparam int W  = $clog2(CLK_FREQ / BAUD) + 8;
  localparam logic [63:0] INC64 =
    (((64'(BAUD) * 64'(OVERSAMPLE)) << W) + 64'(CLK_FREQ / 2)) / 64'(CLK_FREQ);
  localparam logic [W-1:0] INC = INC64[W-1:0];
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_BITS + 2;
  localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

  logic [W-1:0]         acc_q, acc_d;
  logic [W:0]           acc_sum;
  logic                 tick;
  logic [1:0]           sync_q, sync_d;
  logic [1:0]           flt_q, flt_d;
  logic                 filt_q, filt_d;
  state_t               state_q, state_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] sr_q, sr_d;
  logic                 perr_q, perr_d;
  logic                 sample, push, brk;
  logic [EW-1:0]        entry, head;
  logic [AW:0]          wr_q, wr_d, rd_q, rd_d;
  logic                 ovf_q, ovf_d;
  logic                 full, empty, pop, wr_en;
  logic [EW-1:0]        mem_q [FIFO_DEPTH];

  always_comb begin
    acc_sum = {1'b0, acc_q} + {1'b0, INC};
    tick    = acc_sum[W];
    acc_d   = acc_sum[W-1:0];
    sync_d  = {sync_q[0], rxd};
    flt_d   = flt_q;
    if (tick) begin
      if (sync_q[1] && flt_q != 2'd3)
        flt_d = flt_q + 2'd1;
      else if (!sync_q[1] && flt_q != 2'd0)
        flt_d = flt_q - 2'd1;
    end
    filt_d = filt_q;
    if (flt_d == 2'd3)
      filt_d = 1'b1;
    else if (flt_d == 2'd0)
      filt_d = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    sr_d    = sr_q;
    perr_d  = perr_q;
    push    = 1'b0;
    brk     = 1'b0;
    sample  = tick && (tcnt_q == MID);
    if (state_q != IDLE && tick)
      tcnt_d = tcnt_q + TW'(1);
    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        bcnt_d = '0;
        if (!filt_q)
          state_d = START;
      end
      START: begin
        perr_d = 1'b0;
        if (sample)
          state_d = filt_q ? IDLE : DATA;
      end
      DATA: begin
        if (sample) begin
          sr_d   = {filt_q, sr_q[DATA_BITS-1:1]};
          bcnt_d = bcnt_q + BW'(1);
          if (bcnt_q == LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (sample) begin
          perr_d  = (^sr_q) ^ filt_q ^ (PARITY_ODD != 0);
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (sample) begin
          push = 1'b1;
          if (filt_q) begin
            state_d = IDLE;
          end else begin
            state_d = WAIT_IDLE;
            brk     = (sr_q == '0);
          end
        end
      end
      WAIT_IDLE: begin
        if (filt_q)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  always_comb begin
    entry  = {~filt_q, perr_q, sr_q};
    empty  = (wr_q == rd_q);
    full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop    = !empty && m_ready;
    wr_en  = push && (!full || pop);
    wr_d   = wr_q + (AW+1)'(wr_en);
    rd_d   = rd_q + (AW+1)'(pop);
    ovf_d  = ovf_q | (push && full && !pop);
    head   = empty ? '0 : mem_q[rd_q[AW-1:0]];
  end

  assign {m_ferr, m_perr, m_data} = head;
  assign m_valid    = !empty;
  assign fifo_count = wr_q - rd_q;
  assign overflow   = ovf_q;
  assign break_det  = brk;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      sync_q  <= 2'b11;
      flt_q   <= 2'd3;
      filt_q  <= 1'b1;
      state_q <= IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      sr_q    <= '0;
      perr_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      sync_q  <= sync_d;
      flt_q   <= flt_d;
      filt_q  <= filt_d;
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      sr_q    <= sr_d;
      perr_q  <= perr_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem_q[wr_q[AW-1:0]] <= entry;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: serial frames in, expected entries queued and compared on pop.
module tb_uart_rx_fifo;

  localparam int BIT  = 50;
  localparam int PODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       m_ready = 1'b1;
  logic [7:0] m_data;
  logic       m_perr, m_ferr, m_valid, overflow, break_det;
  logic [2:0] fifo_count;

  int n_checks = 0;
  int n_errors = 0;
  int brk_cnt  = 0;
  int n_pops   = 0;
  int snap_brk, snap_pops;
  logic [31:0] sb[$];
  logic [31:0] mon_exp;

  always #5 clk = ~clk;

  uart_rx_fifo #(.FIFO_DEPTH(4), .PARITY_ODD(PODD)) dut (
    .clk(clk), .rst(rst), .rxd(rxd),
    .m_data(m_data), .m_perr(m_perr), .m_ferr(m_ferr),
    .m_valid(m_valid), .m_ready(m_ready), .fifo_count(fifo_count),
    .overflow(overflow), .break_det(break_det)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ent(input logic [7:0] d, input logic ferr, input logic perr);
    return 32'({ferr, perr, d});
  endfunction

  task automatic hold(input logic v, input int n);
    rxd = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop);
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(d[i], BIT);
    if (PAR_EN) hold((^d) ^ PODD[0] ^ flip, BIT);
    hold(stop, BIT);
    hold(1'b1, 2 * BIT);
  endtask

  task automatic check_reset(input string pfx);
    @(negedge clk);
    check_val({pfx, "_valid"}, 32'(m_valid), 0);
    check_val({pfx, "_data"},  32'(m_data), 0);
    check_val({pfx, "_perr"},  32'(m_perr), 0);
    check_val({pfx, "_ferr"},  32'(m_ferr), 0);
    check_val({pfx, "_count"}, 32'(fifo_count), 0);
    check_val({pfx, "_ovf"},   32'(overflow), 0);
    check_val({pfx, "_brk"},   32'(break_det), 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (break_det === 1'b1) brk_cnt++;
    if (!rst && m_valid && m_ready) begin
      mon_exp = 32'hDEAD_BEEF;
      if (sb.size() > 0) mon_exp = sb.pop_front();
      check_val("rx_entry", 32'({m_ferr, m_perr, m_data}), mon_exp);
      n_pops++;
    end
  end

  initial begin
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset("rst");

    // basic 8N1 traffic
    sb.push_back(ent(8'h55, 1'b0, 1'b0));
    send_frame(8'h55, 1'b0, 1'b1);
    sb.push_back(ent(8'hA3, 1'b0, 1'b0));
    send_frame(8'hA3, 1'b0, 1'b1);
    @(negedge clk);
    check_val("drain_count", 32'(fifo_count), 0);
    check_val("drain_sb", 32'(sb.size()), 0);
    @(posedge clk);
    #1;

`ifdef UART_RX_PARITY_EN
    sb.push_back(ent(8'h07, 1'b0, 1'b0));
    send_frame(8'h07, 1'b0, 1'b1);
    sb.push_back(ent(8'h07, 1'b0, 1'b1));
    send_frame(8'h07, 1'b1, 1'b1);
`endif

    // framing error, not a break
    snap_brk = brk_cnt;
    sb.push_back(ent(8'h3C, 1'b1, 1'b0));
    send_frame(8'h3C, 1'b0, 1'b0);
    check_val("ferr_no_brk", 32'(brk_cnt - snap_brk), 0);

    // break: 20 bit times low
    snap_brk  = brk_cnt;
    snap_pops = n_pops;
    sb.push_back(ent(8'h00, 1'b1, PAR_EN & PODD[0]));
    hold(1'b0, 20 * BIT);
    hold(1'b1, 3 * BIT);
    check_val("brk_pulses", 32'(brk_cnt - snap_brk), 1);
    check_val("brk_entries", 32'(n_pops - snap_pops), 1);

    // overflow with consumer stalled
    m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) sb.push_back(ent(8'(i * 8'h11), 1'b0, 1'b0));
      send_frame(8'(i * 8'h11), 1'b0, 1'b1);
    end
    @(negedge clk);
    check_val("ovf_count", 32'(fifo_count), 4);
    check_val("ovf_flag", 32'(overflow), 1);
    check_val("ovf_valid", 32'(m_valid), 1);
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_val("ovf_empty", 32'(m_valid), 0);
    check_val("ovf_sticky", 32'(overflow), 1);
    check_val("ovf_sb", 32'(sb.size()), 0);
    @(posedge clk);
    #1;

    // short low glitches must not start a character
    snap_pops = n_pops;
    hold(1'b0, 12);
    hold(1'b1, 3 * BIT);
    hold(1'b0, 19);
    hold(1'b1, 3 * BIT);
    @(negedge clk);
    check_val("glitch_pops", 32'(n_pops - snap_pops), 0);
    check_val("glitch_count", 32'(fifo_count), 0);
    @(posedge clk);
    #1;

    // reset in the middle of a character with one entry buffered
    m_ready = 1'b0;
    send_frame(8'h99, 1'b0, 1'b1);
    @(negedge clk);
    check_val("pre_rst_count", 32'(fifo_count), 1);
    @(posedge clk);
    #1;
    hold(1'b0, BIT);
    hold(1'b1, BIT);
    hold(1'b0, 2 * BIT);
    rst = 1'b1;
    rxd = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset("midrst");
    m_ready = 1'b1;
    hold(1'b1, 2 * BIT);
    sb.push_back(ent(8'h81, 1'b0, 1'b0));
    send_frame(8'h81, 1'b0, 1'b1);
    @(negedge clk);
    check_val("post_rst_sb", 32'(sb.size()), 0);
    check_val("post_rst_count", 32'(fifo_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
